dmem_ctrl_v2: RTL and testbench

Parametrised data-memory controller for the RV32I/RV64I load-store unit.
- Accepts byte-addressed load/store requests over a valid/ready handshake.
- Aligns write data and byte lanes to the address offset, then sign- or zero-extends load data from any lane.
- Returns exactly one response per request.
- Wraps a single-port byte-writable BRAM and sits between the LSU and local data memory.

---
 rtl/dmem_pkg.sv | 53 +++++
 rtl/bram_sp_be.sv | 33 +++
 rtl/dmem_ctrl_v2.sv | 197 +++++++++++++++++++
 tb/tb_dmem_ctrl_v2.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_ctrl_v2 data-memory controller:
// access-size and FSM enums, the base byte-lane mask, and alignment helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_OUT  = 2'd2
    } dmem_state_e;

    // Base byte-lane mask for an access of the given size at offset 0.
    function automatic logic [7:0] size_mask(input mem_size_e size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            SZ_D:    m = 8'hFF;
            default: m = 8'h01;
        endcase
        return m;
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] low_bits(input mem_size_e size);
        logic [2:0] b;
        case (size)
            SZ_B:    b = 3'd0;
            SZ_H:    b = 3'd1;
            SZ_W:    b = 3'd3;
            SZ_D:    b = 3'd7;
            default: b = 3'd0;
        endcase
        return b;
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] offset);
        return (offset & low_bits(size)) != 3'd0;
    endfunction

    // Offset rounded down to natural alignment for the access size.
    function automatic logic [2:0] align_offset(input mem_size_e size, input logic [2:0] offset);
        return offset & ~low_bits(size);
    endfunction

endpackage

// File: rtl/bram_sp_be.sv
// Single-port block RAM with per-byte write enables and a registered read.
// The read returns the word contents from before a same-cycle write.
module bram_sp_be #(
    parameter int DEPTH  = 4096,
    parameter int NBYTES = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [NBYTES-1:0]     be_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [8*NBYTES-1:0]   wdata_i,
    output logic [8*NBYTES-1:0]   rdata_o
);

    logic [8*NBYTES-1:0] mem_q [DEPTH];
    logic [8*NBYTES-1:0] rdata_q;

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl_v2.sv
// Data-memory controller between the LSU and a byte-writable local BRAM.
// Aligns store data/lanes, extracts and extends load data, one response
// per request. Build option DMEM_MISALIGN_TRAP_EN: when defined, misaligned
// accesses are rejected with rsp_err in the next cycle; when undefined they
// are forced to natural alignment and performed.
module dmem_ctrl_v2
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int XLEN    = 32,
    parameter int OUT_REG = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_we,
    input  logic [$clog2(DEPTH)+$clog2(XLEN/8)-1:0]       req_addr,
    input  logic [1:0]                                    req_size,
    input  logic                                          req_unsigned,
    input  logic [XLEN-1:0]                               req_wdata,
    output logic                                          rsp_valid,
    output logic [XLEN-1:0]                               rsp_rdata,
    output logic                                          rsp_err
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);
    localparam int WIDXW  = $clog2(DEPTH);
    localparam int ADDRW  = WIDXW + OFFW;

    // Request decode
    logic [OFFW-1:0]   off_s;
    logic [OFFW-1:0]   off_al_s;
    logic [2:0]        off3_s;
    logic [2:0]        off3_al_s;
    mem_size_e         size_s;
    logic              illegal_s;
    logic              trap_s;
    logic              accept_s;
    logic              access_s;
    logic [15:0]       be_wide_s;
    logic [NBYTES-1:0] ram_be_s;
    logic [XLEN-1:0]   ram_wdata_s;
    logic [XLEN-1:0]   ram_rdata_s;

    // Load extraction
    logic [XLEN-1:0]   shifted_s;
    logic [XLEN-1:0]   ext_s;
    logic [5:0]        msb_s;
    logic              sign_s;

    // Registered state
    dmem_state_e       state_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              rsp_err_q;
    mem_size_e         size_q;
    logic              uns_q;
    logic [OFFW-1:0]   off_q;
    logic              err_q;
    logic [XLEN-1:0]   hold_q;

    // Decode the incoming request: legality, alignment and byte-lane steering.
    always_comb begin
        off_s     = req_addr[OFFW-1:0];
        off3_s    = 3'd0;
        off3_s[OFFW-1:0] = off_s;
        size_s    = mem_size_e'(req_size);
        illegal_s = (XLEN == 32) && (size_s == SZ_D);
        off3_al_s = align_offset(size_s, off3_s);
        off_al_s  = off3_al_s[OFFW-1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        trap_s    = ~illegal_s & is_misaligned(size_s, off3_s);
`else
        trap_s    = 1'b0;
`endif
        accept_s  = req_valid & ready_q;
        access_s  = accept_s & ~illegal_s & ~trap_s;
        be_wide_s = {8'h00, size_mask(size_s)} << off_al_s;
        if (access_s && req_we) begin
            ram_be_s = be_wide_s[NBYTES-1:0];
        end else begin
            ram_be_s = {NBYTES{1'b0}};
        end
        ram_wdata_s = req_wdata << {off_al_s, 3'b000};
    end

    bram_sp_be #(
        .DEPTH  (DEPTH),
        .NBYTES (NBYTES),
        .AW     (WIDXW)
    ) u_bram (
        .clk     (clk),
        .en_i    (access_s),
        .be_i    (ram_be_s),
        .addr_i  (req_addr[ADDRW-1:OFFW]),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Select the loaded field and sign- or zero-extend it to XLEN.
    always_comb begin
        shifted_s = ram_rdata_s >> {off_q, 3'b000};
        case (size_q)
            SZ_B:    msb_s = 6'd7;
            SZ_H:    msb_s = 6'd15;
            SZ_W:    msb_s = 6'd31;
            SZ_D:    msb_s = 6'd63;
            default: msb_s = 6'd7;
        endcase
        sign_s = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (6'(i) == msb_s) begin
                sign_s = shifted_s[i] & ~uns_q;
            end else begin
                sign_s = sign_s;
            end
        end
        ext_s = {XLEN{1'b0}};
        for (int i = 0; i < XLEN; i++) begin
            if (6'(i) <= msb_s) begin
                ext_s[i] = shifted_s[i];
            end else begin
                ext_s[i] = sign_s;
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {XLEN{1'b0}};
            rsp_err_q   <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            off_q       <= {OFFW{1'b0}};
            err_q       <= 1'b0;
            hold_q      <= {XLEN{1'b0}};
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {XLEN{1'b0}};
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        if (req_we || trap_s) begin
                            // Stores and trapped accesses answer next cycle.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= trap_s | illegal_s;
                        end else begin
                            state_q <= RD_WAIT;
                            ready_q <= 1'b0;
                            size_q  <= size_s;
                            uns_q   <= req_unsigned;
                            off_q   <= off_al_s;
                            err_q   <= illegal_s;
                        end
                    end
                end
                RD_WAIT: begin
                    if (OUT_REG == 0) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= err_q ? {XLEN{1'b0}} : ext_s;
                        rsp_err_q   <= err_q;
                    end else begin
                        state_q <= RD_OUT;
                        hold_q  <= err_q ? {XLEN{1'b0}} : ext_s;
                    end
                end
                RD_OUT: begin
                    state_q     <= IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= hold_q;
                    rsp_err_q   <= err_q;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl_v2.sv
// Directed bench for dmem_ctrl_v2: a 32-bit instance with OUT_REG=1 and a
// 64-bit instance with OUT_REG=0, sharing clock and reset.
module tb_dmem_ctrl_v2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance, DEPTH 4096 -> 14-bit byte address
    logic        a_valid, a_ready, a_we, a_uns, a_rsp_valid, a_rsp_err;
    logic [13:0] a_addr;
    logic [1:0]  a_size;
    logic [31:0] a_wdata, a_rdata;

    // 64-bit instance, DEPTH 256 -> 11-bit byte address
    logic        b_valid, b_ready, b_we, b_uns, b_rsp_valid, b_rsp_err;
    logic [10:0] b_addr;
    logic [1:0]  b_size;
    logic [63:0] b_wdata, b_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_ctrl_v2 #(.DEPTH(4096), .XLEN(32), .OUT_REG(1)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_addr(a_addr), .req_size(a_size),
        .req_unsigned(a_uns), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rdata), .rsp_err(a_rsp_err)
    );

    dmem_ctrl_v2 #(.DEPTH(256), .XLEN(64), .OUT_REG(0)) u_dut64 (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_size(b_size),
        .req_unsigned(b_uns), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for its response and check latency,
    // data, error flag, and how many cycles req_ready was held low.
    task automatic do_req(input bit sel64, input bit we, input logic [63:0] addr,
                          input logic [1:0] size, input bit uns, input logic [63:0] wdata,
                          input logic [63:0] exp_data, input bit exp_err, input int exp_lat,
                          input string tag);
        int   lat;
        int   low;
        logic rv;
        logic rdy;
        @(posedge clk); #1;
        if (sel64) begin
            b_valid = 1'b1; b_we = we; b_addr = addr[10:0]; b_size = size;
            b_uns = uns; b_wdata = wdata; rdy = b_ready;
        end else begin
            a_valid = 1'b1; a_we = we; a_addr = addr[13:0]; a_size = size;
            a_uns = uns; a_wdata = wdata[31:0]; rdy = a_ready;
        end
        check_val({tag, "/ready_in"}, 64'(rdy), 64'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        lat = 1;
        low = 0;
        rv  = sel64 ? b_rsp_valid : a_rsp_valid;
        rdy = sel64 ? b_ready : a_ready;
        while (!rv && lat < 8) begin
            if (!rdy) low++;
            @(posedge clk); #1;
            lat++;
            rv  = sel64 ? b_rsp_valid : a_rsp_valid;
            rdy = sel64 ? b_ready : a_ready;
        end
        check_val({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "/rdata"}, sel64 ? b_rdata : {32'h0, a_rdata}, exp_data);
        check_val({tag, "/err"}, 64'(sel64 ? b_rsp_err : a_rsp_err), 64'(exp_err));
        check_val({tag, "/ready_rsp"}, 64'(rdy), 64'd1);
        check_val({tag, "/ready_low"}, 64'(low), 64'(exp_lat - 1));
    endtask

    initial begin : stim
        int   pulses;
        logic seen;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 14'h0; a_size = 2'd0; a_uns = 1'b0; a_wdata = 32'h0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 11'h0; b_size = 2'd0; b_uns = 1'b0; b_wdata = 64'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_val("reset/ready", 64'(a_ready), 64'd1);
        check_val("reset/rsp_valid", 64'(a_rsp_valid), 64'd0);
        check_val("reset/rdata", {32'h0, a_rdata}, 64'h0);
        check_val("reset/err", 64'(a_rsp_err), 64'd0);
        check_val("reset/ready64", 64'(b_ready), 64'd1);

        // Word store, then byte/half loads from various lanes
        do_req(1'b0, 1'b1, 64'h10, 2'd2, 1'b0, 64'hDEADBEEF, 64'h0, 1'b0, 1, "st_w_10");
        do_req(1'b0, 1'b0, 64'h13, 2'd0, 1'b0, 64'h0, 64'hFFFFFFDE, 1'b0, 3, "ld_b_s_13");
        do_req(1'b0, 1'b0, 64'h13, 2'd0, 1'b1, 64'h0, 64'h000000DE, 1'b0, 3, "ld_b_u_13");
        do_req(1'b0, 1'b0, 64'h10, 2'd1, 1'b0, 64'h0, 64'hFFFFBEEF, 1'b0, 3, "ld_h_s_10");
        do_req(1'b0, 1'b0, 64'h12, 2'd1, 1'b1, 64'h0, 64'h0000DEAD, 1'b0, 3, "ld_h_u_12");

        // Half store into upper lanes leaves lower lanes intact
        do_req(1'b0, 1'b1, 64'h20, 2'd2, 1'b0, 64'hCAFEF00D, 64'h0, 1'b0, 1, "st_w_20");
        do_req(1'b0, 1'b1, 64'h22, 2'd1, 1'b0, 64'h00008001, 64'h0, 1'b0, 1, "st_h_22");
        do_req(1'b0, 1'b0, 64'h20, 2'd2, 1'b0, 64'h0, 64'h8001F00D, 1'b0, 3, "ld_w_20");
        do_req(1'b0, 1'b0, 64'h22, 2'd1, 1'b0, 64'h0, 64'hFFFF8001, 1'b0, 3, "ld_h_s_22");

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(1'b0, 1'b1, 64'h21, 2'd2, 1'b0, 64'h55667788, 64'h0, 1'b1, 1, "mis_st_w_21");
        do_req(1'b0, 1'b0, 64'h20, 2'd2, 1'b0, 64'h0, 64'h8001F00D, 1'b0, 3, "mis_chk_20");
        do_req(1'b0, 1'b0, 64'h11, 2'd1, 1'b0, 64'h0, 64'h0, 1'b1, 1, "mis_ld_h_11");
`else
        do_req(1'b0, 1'b1, 64'h21, 2'd2, 1'b0, 64'h55667788, 64'h0, 1'b0, 1, "mis_st_w_21");
        do_req(1'b0, 1'b0, 64'h20, 2'd2, 1'b0, 64'h0, 64'h55667788, 1'b0, 3, "mis_chk_20");
        do_req(1'b0, 1'b0, 64'h11, 2'd1, 1'b0, 64'h0, 64'hFFFFBEEF, 1'b0, 3, "mis_ld_h_11");
`endif

        // Illegal dword size on a 32-bit instance
        do_req(1'b0, 1'b1, 64'h10, 2'd3, 1'b0, 64'h12345678, 64'h0, 1'b1, 1, "ill_st_d");
        do_req(1'b0, 1'b0, 64'h10, 2'd2, 1'b0, 64'h0, 64'hDEADBEEF, 1'b0, 3, "ill_chk_10");
        do_req(1'b0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 64'h0, 1'b1, 3, "ill_ld_d");

        // Back-to-back stores with req_valid held high
        pulses = 0;
        @(posedge clk); #1;
        a_valid = 1'b1; a_we = 1'b1; a_size = 2'd2; a_uns = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_addr  = 14'h40 + 14'(4 * i);
            a_wdata = 32'h11111111 * 32'(i + 1);
            check_val($sformatf("b2b/ready%0d", i), 64'(a_ready), 64'd1);
            @(posedge clk); #1;
            if (a_rsp_valid) pulses++;
        end
        a_valid = 1'b0;
        check_val("b2b/pulses", 64'(pulses), 64'd4);
        do_req(1'b0, 1'b0, 64'h4C, 2'd2, 1'b0, 64'h0, 64'h44444444, 1'b0, 3, "b2b_ld_4c");

        // Byte store touches only its lane even with junk in upper data bits
        do_req(1'b0, 1'b1, 64'h41, 2'd0, 1'b0, 64'hFFFFFFA5, 64'h0, 1'b0, 1, "st_b_41");
        do_req(1'b0, 1'b0, 64'h40, 2'd2, 1'b0, 64'h0, 64'h1111A511, 1'b0, 3, "ld_w_40");

        // Reset while a load sits in RD_WAIT
        @(posedge clk); #1;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 14'h10; a_size = 2'd2; a_uns = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check_val("rstmid/ready_wait", 64'(a_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rstmid/rsp_valid", 64'(a_rsp_valid), 64'd0);
        check_val("rstmid/ready", 64'(a_ready), 64'd1);
        check_val("rstmid/rdata", {32'h0, a_rdata}, 64'h0);
        check_val("rstmid/err", 64'(a_rsp_err), 64'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (a_rsp_valid) seen = 1'b1;
        end
        check_val("rstmid/no_rsp", 64'(seen), 64'd0);
        do_req(1'b0, 1'b0, 64'h10, 2'd2, 1'b0, 64'h0, 64'hDEADBEEF, 1'b0, 3, "rstmid_ld_10");

        // 64-bit instance, OUT_REG=0
        do_req(1'b1, 1'b1, 64'h8, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1, "x64_st_d_8");
        do_req(1'b1, 1'b0, 64'hC, 2'd2, 1'b0, 64'h0, 64'h0000000001234567, 1'b0, 2, "x64_ld_w_s_c");
        do_req(1'b1, 1'b0, 64'h8, 2'd2, 1'b1, 64'h0, 64'h0000000089ABCDEF, 1'b0, 2, "x64_ld_w_u_8");
        do_req(1'b1, 1'b0, 64'h8, 2'd2, 1'b0, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, 2, "x64_ld_w_s_8");
        do_req(1'b1, 1'b0, 64'hF, 2'd0, 1'b0, 64'h0, 64'h0000000000000001, 1'b0, 2, "x64_ld_b_s_f");
        do_req(1'b1, 1'b0, 64'hA, 2'd1, 1'b0, 64'h0, 64'hFFFFFFFFFFFF89AB, 1'b0, 2, "x64_ld_h_s_a");
        do_req(1'b1, 1'b0, 64'h8, 2'd3, 1'b0, 64'h0, 64'h0123456789ABCDEF, 1'b0, 2, "x64_ld_d_8");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
